// File: rtl/if_pkg.sv
// Shared types and constants for the IF-stage fetch controller.
// Slot record, the NOP filler instruction and the counter-width helper.
package if_pkg;

  localparam int unsigned SLOT_XLEN = 32;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  typedef struct packed {
    logic [SLOT_XLEN-1:0] pc;
    logic [SLOT_XLEN-1:0] instr;
    logic                 filled;
  } fetch_slot_t;

  // Width needed to hold a count in 0..depth inclusive.
  function automatic int unsigned cnt_width(input int unsigned depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/fetch_slot_buf.sv
// Circular buffer pairing each fetch PC with its returned instruction.
// Separate alloc (tail), fill (oldest pending) and pop (head) pointers.
module fetch_slot_buf
  import if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  alloc_i,
  input  logic [DATA_WIDTH-1:0] alloc_pc_i,
  input  logic                  fill_i,
  input  logic [DATA_WIDTH-1:0] fill_data_i,
  input  logic                  pop_i,
  output logic                  head_valid_o,
  output logic [DATA_WIDTH-1:0] head_pc_o,
  output logic [DATA_WIDTH-1:0] head_instr_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DATA_WIDTH-1:0] r_pc    [DEPTH];
  logic [DATA_WIDTH-1:0] r_instr [DEPTH];
  logic [DEPTH-1:0]      r_filled;
  logic [DEPTH-1:0]      w_filled_d;
  logic [PtrW-1:0]       r_alloc_ptr;
  logic [PtrW-1:0]       r_fill_ptr;
  logic [PtrW-1:0]       r_pop_ptr;

  // Head and fill target never coincide: the head is only popped once filled,
  // and the fill pointer always addresses a pending slot.
  always_comb begin
    w_filled_d = r_filled;
    if (pop_i) begin
      w_filled_d[r_pop_ptr] = 1'b0;
    end
    if (fill_i) begin
      w_filled_d[r_fill_ptr] = 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_pc[i]    <= '0;
        r_instr[i] <= DATA_WIDTH'(NOP_INSTR);
      end
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_pop_ptr   <= '0;
    end else if (flush_i) begin
      r_filled    <= '0;
      r_alloc_ptr <= '0;
      r_fill_ptr  <= '0;
      r_pop_ptr   <= '0;
    end else begin
      if (alloc_i) begin
        r_pc[r_alloc_ptr] <= alloc_pc_i;
        r_alloc_ptr       <= r_alloc_ptr + PtrW'(1);
      end
      if (fill_i) begin
        r_instr[r_fill_ptr] <= fill_data_i;
        r_fill_ptr          <= r_fill_ptr + PtrW'(1);
      end
      if (pop_i) begin
        r_pop_ptr <= r_pop_ptr + PtrW'(1);
      end
      r_filled <= w_filled_d;
    end
  end

  assign head_valid_o = r_filled[r_pop_ptr];
  assign head_pc_o    = r_pc[r_pop_ptr];
  assign head_instr_o = r_instr[r_pop_ptr];

endmodule

// File: rtl/if_fetch_ctrl.sv
// IF-stage fetch controller: issues in-order imem requests, pairs responses
// with their PCs for ID, stalls the PC counter and kills wrong-path work.
module if_fetch_ctrl
  import if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH      = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic [DATA_WIDTH-1:0] pc_i,
  input  logic                  redirect_i,
  output logic                  stall_o,
  output logic                  imem_req_valid_o,
  input  logic                  imem_req_ready_i,
  output logic [DATA_WIDTH-1:0] imem_req_addr_o,
  input  logic                  imem_rsp_valid_i,
  input  logic [DATA_WIDTH-1:0] imem_rsp_data_i,
  output logic                  id_valid_o,
  input  logic                  id_ready_i,
  output logic [DATA_WIDTH-1:0] id_pc_o,
  output logic [DATA_WIDTH-1:0] id_instr_o
);

  localparam int unsigned CntW  = cnt_width(DEPTH);
  // Stale responses can outlive one flush, so the kill counter gets headroom.
  localparam int unsigned KillW = cnt_width(2 * DEPTH);
  localparam logic [CntW-1:0] DepthC = CntW'(DEPTH);

  logic              r_active;
  logic [CntW-1:0]   r_inflight;
  logic [CntW-1:0]   r_buffered;
  logic [KillW-1:0]  r_kill_cnt;
  logic [CntW-1:0]   w_inflight_d;
  logic [CntW-1:0]   w_buffered_d;
  logic [KillW-1:0]  w_kill_d;
  logic [KillW-1:0]  w_kill_sum;
  logic [CntW-1:0]   w_used;
  logic              w_req_fire;
  logic              w_rsp_fill;
  logic              w_rsp_kill;
  logic              w_pop;
  logic              w_head_valid;

  assign w_used = r_inflight + r_buffered;

  assign imem_req_valid_o = r_active && !redirect_i && (w_used < DepthC)
                            && ((r_kill_cnt == '0) || (w_used < DepthC));
  assign imem_req_addr_o  = pc_i;
  assign w_req_fire       = imem_req_valid_o && imem_req_ready_i;
  assign stall_o          = !w_req_fire;

  assign w_rsp_fill = imem_rsp_valid_i && (r_kill_cnt == '0) && !redirect_i;
  assign w_rsp_kill = imem_rsp_valid_i && (r_kill_cnt != '0);
  assign w_pop      = w_head_valid && id_ready_i && !redirect_i;
  assign w_kill_sum = r_kill_cnt + KillW'(r_inflight);

  always_comb begin
    w_inflight_d = r_inflight + CntW'(w_req_fire) - CntW'(w_rsp_fill);
    w_buffered_d = r_buffered + CntW'(w_rsp_fill) - CntW'(w_pop);
    w_kill_d     = r_kill_cnt - KillW'(w_rsp_kill);
    if (redirect_i) begin
      // Everything in flight becomes stale; a response landing now is dropped.
      w_inflight_d = '0;
      w_buffered_d = '0;
      w_kill_d     = w_kill_sum;
      if (imem_rsp_valid_i && (w_kill_sum != '0)) begin
        w_kill_d = w_kill_sum - KillW'(1);
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_active   <= 1'b0;
      r_inflight <= '0;
      r_buffered <= '0;
      r_kill_cnt <= '0;
    end else begin
      r_active   <= 1'b1;
      r_inflight <= w_inflight_d;
      r_buffered <= w_buffered_d;
      r_kill_cnt <= w_kill_d;
    end
  end

  fetch_slot_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_slot_buf (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .flush_i      (redirect_i),
    .alloc_i      (w_req_fire),
    .alloc_pc_i   (pc_i),
    .fill_i       (w_rsp_fill),
    .fill_data_i  (imem_rsp_data_i),
    .pop_i        (w_pop),
    .head_valid_o (w_head_valid),
    .head_pc_o    (id_pc_o),
    .head_instr_o (id_instr_o)
  );

  assign id_valid_o = w_head_valid;

endmodule
